// File: rtl/slave_bus_if.sv
// Request/response bus shared by the requesters and the downstream memory port.
// The requester side drives the request fields. The memory side answers with
// bdone and rdata.
interface slave_bus_if;
    logic        bstart;
    logic [31:0] addr;
    logic        ttype;   // 1'b0 = READ, 1'b1 = WRITE
    logic [1:0]  tsize;
    logic [31:0] wdata;
    logic        ss;
    logic        bdone;
    logic [31:0] rdata;

    modport master (
        output bstart, addr, ttype, tsize, wdata, ss,
        input  bdone, rdata
    );

    modport slave (
        input  bstart, addr, ttype, tsize, wdata, ss,
        output bdone, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported memory.
// The two requesters are instruction fetch (ibus) and load/store (dbus).
// Ties are broken round-robin. Each grant issues exactly one downstream bstart.
// A transaction is aborted with a timeout pulse if the memory never answers.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    slave_bus_if.slave   ibus,
    slave_bus_if.slave   dbus,
    slave_bus_if.master  mbus,
    output logic [1:0]   grant,
    output logic         timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic       OWN_IBUS  = 1'b0;
    localparam logic       OWN_DBUS  = 1'b1;
    // The last WAIT cycle index before the transaction is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    state_t      state_nx_s;
    logic        owner_r;
    logic        owner_nx_s;
    logic        last_owner_r;
    logic        last_owner_nx_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_nx_s;
    logic [1:0]  grant_r;
    logic [1:0]  grant_nx_s;
    logic        bstart_r;
    logic        bstart_nx_s;
    logic        winner_s;
    logic        done_s;
    logic        abort_s;
    logic [31:0] resp_data_s;

    // Pick the winner. A lone requester wins. On a tie, the side that did not own the bus last time wins.
    always_comb begin
        winner_s = OWN_IBUS;
        if (ibus.bstart && dbus.bstart) begin
            winner_s = ~last_owner_r;
        end else if (dbus.bstart) begin
            winner_s = OWN_DBUS;
        end else begin
            winner_s = OWN_IBUS;
        end
    end

    // Next-state logic, completion and abort detection
    always_comb begin
        state_nx_s      = state_r;
        owner_nx_s      = owner_r;
        last_owner_nx_s = last_owner_r;
        wait_cnt_nx_s   = wait_cnt_r;
        grant_nx_s      = grant_r;
        bstart_nx_s     = 1'b0;
        done_s          = 1'b0;
        abort_s         = 1'b0;
        resp_data_s     = 32'd0;
        case (state_r)
            ST_IDLE: begin
                wait_cnt_nx_s = 8'd0;
                if (ibus.bstart || dbus.bstart) begin
                    state_nx_s      = ST_ISSUE;
                    owner_nx_s      = winner_s;
                    last_owner_nx_s = winner_s;
                    grant_nx_s      = (winner_s == OWN_DBUS) ? 2'b10 : 2'b01;
                    bstart_nx_s     = 1'b1;
                end else begin
                    grant_nx_s = 2'b00;
                end
            end
            ST_ISSUE: begin
                // A stray mbus.bdone here is ignored; ISSUE always lasts exactly one cycle.
                state_nx_s    = ST_WAIT;
                wait_cnt_nx_s = 8'd0;
            end
            ST_WAIT: begin
                if (mbus.bdone) begin
                    // A real completion takes priority over a timeout in the same cycle.
                    done_s        = 1'b1;
                    resp_data_s   = mbus.rdata;
                    state_nx_s    = ST_IDLE;
                    grant_nx_s    = 2'b00;
                    wait_cnt_nx_s = 8'd0;
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    done_s        = 1'b1;
                    abort_s       = 1'b1;
                    state_nx_s    = ST_IDLE;
                    grant_nx_s    = 2'b00;
                    wait_cnt_nx_s = 8'd0;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nx_s    = ST_IDLE;
                grant_nx_s    = 2'b00;
                wait_cnt_nx_s = 8'd0;
            end
        endcase
    end

    // State, ownership, wait counter and registered grant/bstart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_IBUS;
            last_owner_r <= OWN_DBUS;
            wait_cnt_r   <= 8'd0;
            grant_r      <= 2'b00;
            bstart_r     <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            owner_r      <= owner_nx_s;
            last_owner_r <= last_owner_nx_s;
            wait_cnt_r   <= wait_cnt_nx_s;
            grant_r      <= grant_nx_s;
            bstart_r     <= bstart_nx_s;
        end
    end

    // Forward the owner's request fields to mbus while a transaction is active; the bus is quiet in IDLE
    always_comb begin
        mbus.bstart = bstart_r;
        mbus.addr   = 32'd0;
        mbus.ttype  = 1'b0;
        mbus.tsize  = 2'd0;
        mbus.wdata  = 32'd0;
        mbus.ss     = 1'b0;
        if ((state_r == ST_ISSUE) || (state_r == ST_WAIT)) begin
            if (owner_r == OWN_DBUS) begin
                mbus.addr  = dbus.addr;
                mbus.ttype = dbus.ttype;
                mbus.tsize = dbus.tsize;
                mbus.wdata = dbus.wdata;
                mbus.ss    = dbus.ss;
            end else begin
                mbus.addr  = ibus.addr;
                mbus.ttype = ibus.ttype;
                mbus.tsize = ibus.tsize;
                mbus.wdata = ibus.wdata;
                mbus.ss    = ibus.ss;
            end
        end else begin
            mbus.addr  = 32'd0;
            mbus.ttype = 1'b0;
            mbus.tsize = 2'd0;
            mbus.wdata = 32'd0;
            mbus.ss    = 1'b0;
        end
    end

    // Return completion to the owner only. The other requester sees bdone=0 and rdata=0.
    always_comb begin
        ibus.bdone = done_s && (owner_r == OWN_IBUS);
        dbus.bdone = done_s && (owner_r == OWN_DBUS);
        if (ibus.bdone) begin
            ibus.rdata = resp_data_s;
        end else begin
            ibus.rdata = 32'd0;
        end
        if (dbus.bdone) begin
            dbus.rdata = resp_data_s;
        end else begin
            dbus.rdata = 32'd0;
        end
    end

    assign grant       = grant_r;
    assign timeout_err = abort_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter.
// Requester drivers feed request queues to ibus and dbus.
// A memory model sits on mbus; its response latency is adjustable and it can be muted.
// A monitor pops expected completions from a queue whenever a bdone appears.
module tb_mem_port_arbiter;
    localparam int unsigned TMO = 4;

    typedef struct {
        logic [31:0] addr;
        logic        ttype;
        logic [1:0]  tsize;
        logic [31:0] wdata;
        logic        ss;
    } req_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        terr;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  grant;
    logic        timeout_err;

    slave_bus_if ibus ();
    slave_bus_if dbus ();
    slave_bus_if mbus ();

    mem_port_arbiter #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ibus        (ibus),
        .dbus        (dbus),
        .mbus        (mbus),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    req_t iq[$];
    req_t dq[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // cycle index, advanced on every rising edge
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory model on mbus ----------------
    logic [31:0] mem [0:63];
    int          lat = 1;
    int          mcnt = 0;
    int          bst_cnt = 0;
    logic [31:0] m_rdata = 32'd0;
    logic        spur = 1'b0;
    logic [31:0] cap_addr = 32'd0;
    logic [31:0] cap_wdata = 32'd0;
    logic        cap_ttype = 1'b0;
    logic        cap_ss = 1'b0;

    // memory: capture on bstart, answer lat cycles later (lat 0 = never answer)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt   <= 0;
            mem[4] <= 32'hDEADBEEF;
            mem[5] <= 32'hCAFEF00D;
            mem[6] <= 32'h11111111;
            mem[7] <= 32'h22222222;
        end else if (mbus.bstart) begin
            bst_cnt   <= bst_cnt + 1;
            cap_addr  <= mbus.addr;
            cap_wdata <= mbus.wdata;
            cap_ttype <= mbus.ttype;
            cap_ss    <= mbus.ss;
            if (lat != 0) begin
                mcnt <= lat;
                if (mbus.ttype) begin
                    mem[mbus.addr[7:2]] <= mbus.wdata;
                    m_rdata <= 32'd0;
                end else begin
                    m_rdata <= mem[mbus.addr[7:2]];
                end
            end
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
        end
    end

    assign mbus.bdone = (mcnt == 1) || spur;
    assign mbus.rdata = m_rdata;

    // ---------------- requester drivers ----------------
    task automatic run_port(input int p);
        logic active = 1'b0;
        logic got = 1'b0;
        int   waited = 0;
        req_t r;
        r = '{addr:32'd0, ttype:1'b0, tsize:2'd0, wdata:32'd0, ss:1'b0};
        forever begin
            @(posedge clk);
            #1;
            if (active && got) begin
                if (p == 0) begin
                    if (iq.size() > 0) iq.delete(0);
                end else begin
                    if (dq.size() > 0) dq.delete(0);
                end
                active = 1'b0;
                got    = 1'b0;
            end
            if (!active) begin
                if (p == 0 && iq.size() > 0) begin
                    r = iq[0]; active = 1'b1; waited = 0;
                end else if (p == 1 && dq.size() > 0) begin
                    r = dq[0]; active = 1'b1; waited = 0;
                end else begin
                    r = '{addr:32'd0, ttype:1'b0, tsize:2'd0, wdata:32'd0, ss:1'b0};
                end
            end
            if (p == 0) begin
                ibus.bstart = active; ibus.addr = r.addr; ibus.ttype = r.ttype;
                ibus.tsize = r.tsize; ibus.wdata = r.wdata; ibus.ss = r.ss;
            end else begin
                dbus.bstart = active; dbus.addr = r.addr; dbus.ttype = r.ttype;
                dbus.tsize = r.tsize; dbus.wdata = r.wdata; dbus.ss = r.ss;
            end
            @(negedge clk);
            if (active) begin
                if ((p == 0) ? ibus.bdone : dbus.bdone) begin
                    got = 1'b1;
                end else begin
                    waited++;
                    if (waited > 60) begin
                        checks++;
                        errors++;
                        $display("FAIL port%0d_bound: no bdone after %0d cycles, required one", p, waited);
                        got = 1'b1;
                    end
                end
            end
        end
    endtask

    initial run_port(0);
    initial run_port(1);

    // ---------------- monitor ----------------
    exp_t e;
    int   mport;
    always @(negedge clk) begin
        if (rst_n) begin
            if (!ibus.bdone) check("ibus_rdata_quiet", ibus.rdata, 32'd0);
            if (!dbus.bdone) check("dbus_rdata_quiet", dbus.rdata, 32'd0);
            if (grant == 2'b00) begin
                check("mbus_idle_ctl", 32'({mbus.bstart, mbus.ss, mbus.ttype, mbus.tsize}), 32'd0);
                check("mbus_idle_addr", mbus.addr, 32'd0);
            end
            if (ibus.bdone || dbus.bdone) begin
                check("bdone_onehot", 32'(ibus.bdone & dbus.bdone), 32'd0);
                mport = dbus.bdone ? 1 : 0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bdone: got bdone on port %0d at cycle %0d, required none", mport, cyc);
                end else begin
                    e = sb.pop_front();
                    check("resp_port", mport, e.port);
                    check("resp_rdata", (mport == 1) ? dbus.rdata : ibus.rdata, e.rdata);
                    check("resp_terr", 32'(timeout_err), 32'(e.terr));
                    check("resp_cycle", cyc, e.cyc);
                    check("resp_grant", 32'(grant), (e.port == 1) ? 32'd2 : 32'd1);
                end
            end else begin
                check("terr_without_bdone", 32'(timeout_err), 32'd0);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic push_req(input int p, input logic [31:0] a, input logic t,
                            input logic [1:0] sz, input logic [31:0] wd, input logic s);
        req_t r;
        r = '{addr:a, ttype:t, tsize:sz, wdata:wd, ss:s};
        if (p == 0) iq.push_back(r);
        else dq.push_back(r);
    endtask

    task automatic push_exp(input int p, input logic [31:0] d, input logic t, input int c);
        sb.push_back('{port:p, rdata:d, terr:t, cyc:c});
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || iq.size() != 0 || dq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses still pending after %0d cycles, required 0", sb.size(), n);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    int t0;
    int b0;
    int b1;
    initial begin
        rst_n = 1'b0;
        #2;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_bdone", 32'({ibus.bdone, dbus.bdone}), 32'd0);
        check("rst_mbus", 32'({mbus.bstart, mbus.ss}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // single ibus read
        @(negedge clk);
        t0 = cyc + 1;
        push_req(0, 32'h10, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(0, 32'hDEADBEEF, 1'b0, t0 + 2);
        @(negedge clk);
        check("t1_grant_c0", 32'(grant), 32'd0);
        @(negedge clk);
        check("t1_grant_c1", 32'(grant), 32'd1);
        check("t1_mbstart_c1", 32'(mbus.bstart), 32'd1);
        check("t1_maddr_c1", mbus.addr, 32'h10);
        @(negedge clk);
        check("t1_grant_c2", 32'(grant), 32'd1);
        check("t1_mbstart_c2", 32'(mbus.bstart), 32'd0);
        drain();

        // simultaneous first requests after reset: ibus first
        do_reset();
        @(negedge clk);
        t0 = cyc + 1;
        push_req(0, 32'h10, 1'b0, 2'b10, 32'd0, 1'b0);
        push_req(1, 32'h14, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(0, 32'hDEADBEEF, 1'b0, t0 + 2);
        push_exp(1, 32'hCAFEF00D, 1'b0, t0 + 5);
        drain();

        // both hold bstart for three transactions each: I,D,I,D,I,D
        @(negedge clk);
        t0 = cyc + 1;
        push_req(0, 32'h18, 1'b0, 2'b10, 32'd0, 1'b0);
        push_req(0, 32'h1C, 1'b0, 2'b10, 32'd0, 1'b0);
        push_req(0, 32'h10, 1'b0, 2'b10, 32'd0, 1'b0);
        push_req(1, 32'h14, 1'b0, 2'b10, 32'd0, 1'b0);
        push_req(1, 32'h10, 1'b0, 2'b10, 32'd0, 1'b0);
        push_req(1, 32'h18, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(0, 32'h11111111, 1'b0, t0 + 2);
        push_exp(1, 32'hCAFEF00D, 1'b0, t0 + 5);
        push_exp(0, 32'h22222222, 1'b0, t0 + 8);
        push_exp(1, 32'hDEADBEEF, 1'b0, t0 + 11);
        push_exp(0, 32'hDEADBEEF, 1'b0, t0 + 14);
        push_exp(1, 32'h11111111, 1'b0, t0 + 17);
        drain();

        // dbus write then ibus read-back
        b0 = bst_cnt;
        @(negedge clk);
        t0 = cyc + 1;
        push_req(1, 32'h20, 1'b1, 2'b10, 32'h12345678, 1'b1);
        push_exp(1, 32'd0, 1'b0, t0 + 2);
        drain();
        check("t4_bstart_count", bst_cnt - b0, 32'd1);
        check("t4_ttype", 32'(cap_ttype), 32'd1);
        check("t4_ss", 32'(cap_ss), 32'd1);
        check("t4_addr", cap_addr, 32'h20);
        check("t4_wdata", cap_wdata, 32'h12345678);
        @(negedge clk);
        t0 = cyc + 1;
        push_req(0, 32'h20, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(0, 32'h12345678, 1'b0, t0 + 2);
        drain();

        // silent memory: abort after TMO wait cycles, then normal service
        lat = 0;
        @(negedge clk);
        t0 = cyc + 1;
        push_req(0, 32'h10, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(0, 32'd0, 1'b1, t0 + 5);
        drain();
        lat = 1;
        @(negedge clk);
        t0 = cyc + 1;
        push_req(1, 32'h14, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(1, 32'hCAFEF00D, 1'b0, t0 + 2);
        drain();

        // bdone arriving exactly on the timeout cycle completes normally
        lat = 4;
        @(negedge clk);
        t0 = cyc + 1;
        push_req(0, 32'h10, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(0, 32'hDEADBEEF, 1'b0, t0 + 5);
        drain();
        lat = 1;

        // stray mbus.bdone in IDLE and in ISSUE is ignored
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        check("t7_idle_grant", 32'(grant), 32'd0);
        t0 = cyc + 1;
        push_req(0, 32'h18, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(0, 32'h11111111, 1'b0, t0 + 2);
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        check("t7_issue_bdone", 32'(ibus.bdone), 32'd0);
        check("t7_issue_grant", 32'(grant), 32'd1);
        @(posedge clk);
        #1;
        spur = 1'b0;
        drain();

        // reset during WAIT of a dbus write, then re-arbitration
        b0 = bst_cnt;
        lat = 0;
        @(negedge clk);
        t0 = cyc + 1;
        push_req(1, 32'h24, 1'b1, 2'b10, 32'hA5A5A5A5, 1'b1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t8_rst_grant", 32'(grant), 32'd0);
        check("t8_rst_terr", 32'(timeout_err), 32'd0);
        check("t8_rst_bdone", 32'({ibus.bdone, dbus.bdone}), 32'd0);
        check("t8_rst_mbus", 32'({mbus.bstart, mbus.ss}), 32'd0);
        check("t8_rst_maddr", mbus.addr, 32'd0);
        lat = 1;
        b1 = bst_cnt;
        check("t8_bstart_before", b1 - b0, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_exp(1, 32'd0, 1'b0, cyc + 2);
        drain();
        check("t8_bstart_after", bst_cnt - b1, 32'd1);
        @(negedge clk);
        t0 = cyc + 1;
        push_req(0, 32'h24, 1'b0, 2'b10, 32'd0, 1'b0);
        push_exp(0, 32'hA5A5A5A5, 1'b0, t0 + 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // run-time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, int unsigned, default 16: max cycles in WAIT for mbus.bdone before abort; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock for all state.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port ibus, slave_bus_if.slave, n/a: instruction-fetch requester, read-only by usage.
REQ-005 SHALL have port dbus, slave_bus_if.slave, n/a: load/store requester, read and write.
REQ-006 SHALL have port mbus, slave_bus_if.master, n/a: single shared downstream port to one single-ported memory_word-style slave.
REQ-007 SHALL have port grant, output, 2: bit0 = ibus owns mbus, bit1 = dbus owns mbus; one-hot or zero.
REQ-008 SHALL have port timeout_err, output, 1: one-cycle pulse on abort.

Function
REQ-009 SHALL treat requester protocol as: bstart held high with addr/ttype/tsize/wdata/ss stable until the cycle bdone=1; bdone is a one-cycle pulse.
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-011 IDLE: SHALL stay in IDLE if neither ibus.bstart nor dbus.bstart; otherwise SHALL register a winner and go to ISSUE.
REQ-012 Arbitration: if only one requests, that one wins; if both, the one not in last_owner wins (round-robin).
REQ-013 last_owner SHALL update to the winner on every IDLE->ISSUE transition; reset value = DBUS, so the first tie goes to ibus.
REQ-014 ISSUE: SHALL drive mbus.bstart=1 for exactly one cycle, then go to WAIT unconditionally.
REQ-015 ISSUE and WAIT: SHALL forward the winner's addr, ttype, tsize, wdata, ss to mbus combinationally.
REQ-016 IDLE: SHALL drive mbus.bstart=0, mbus.ss=0, and all other mbus request fields 0.
REQ-017 WAIT: when mbus.bdone=1, SHALL assert the winner's bdone in the same cycle, pass mbus.rdata to the winner's rdata, and go to IDLE.
REQ-018 Loser bdone SHALL be 0 and loser rdata SHALL be 0 at all times; the loser's bstart stays pending and is not dropped.
REQ-019 Nominal latency SHALL be 2 cycles from the IDLE cycle that samples bstart to the winner's bdone (memory responds one cycle after its bstart).
REQ-020 WAIT SHALL run a wait counter, cleared on entry; if it reaches TIMEOUT without mbus.bdone, SHALL assert winner bdone with rdata=0, pulse timeout_err, and go to IDLE.
REQ-021 mbus.bdone in IDLE or ISSUE SHALL be ignored: no requester bdone, no state change.
REQ-022 bdone and timeout reached in the same cycle: normal completion wins; timeout_err stays 0.
REQ-023 A requester re-asserting bstart in the IDLE cycle after its bdone SHALL be arbitrated normally; round-robin still applies if the other requester is pending.
REQ-024 grant SHALL reflect the registered winner in ISSUE and WAIT, and SHALL be 2'b00 in IDLE.
REQ-025 Each grant SHALL produce exactly one mbus.bstart pulse, so one downstream write per dbus write transaction.

Reset
REQ-026 On rst_n low, asynchronously and regardless of state, SHALL force: state=IDLE, last_owner=DBUS, wait counter=0, grant=0, timeout_err=0, ibus.bdone=0, dbus.bdone=0, mbus.bstart=0, mbus.ss=0.
REQ-027 A transaction in flight at reset SHALL be discarded with no bdone issued; after rst_n rises, still-held bstart requests SHALL be re-arbitrated from IDLE.

Verification
REQ-028 ibus read only, addr=0x10, memory rdata=0xDEADBEEF -> mbus.bstart at cycle 1, ibus.bdone=1 with rdata 0xDEADBEEF at cycle 2, grant=01 in cycles 1-2.
REQ-029 ibus and dbus both request in the first cycle after reset -> ibus served first (bdone at cycle 2), dbus served next (bdone at cycle 5); dbus.bdone=0 while ibus is served.
REQ-030 Both requesters hold bstart continuously for 6 transactions -> grants alternate I,D,I,D,I,D; no back-to-back grant to the same requester.
REQ-031 dbus write, ss=1, addr=0x20, wdata=0x12345678 -> exactly one mbus.bstart with ttype=WRITE; a following ibus read of 0x20 returns 0x12345678.
REQ-032 TIMEOUT=4, slave never asserts bdone -> winner bdone=1 with rdata=0 and timeout_err=1 pulse after 4 WAIT cycles; next request is serviced normally.
REQ-033 rst_n low during WAIT of a dbus write -> all outputs 0 immediately; after release with dbus.bstart held, a fresh arbitration and a single new mbus.bstart occur.
